pipeline_trace_buffer: RTL and testbench
========================================

Name: pipeline_trace_buffer

Overview:
- Synthesizable on-chip trace capture for the MIPS pipeline. It replaces per-cycle monitor printing with hardware capture.
- Samples NUM_CH stage channels (IF/ID, ID/EX, EX/MEM, MEM/WB, WB by default) into a circular buffer, stamping each sample with a free-running cycle count.
- On a trigger it captures a fixed post-trigger window, then streams the buffer out oldest-first over a valid/ready port.

Parameters:
- NUM_CH, 5, number of traced channels.
- CH_W, 32, width of each channel word.
- DEPTH, 16, buffer entries; power of 2, >= 2.
- POST_TRIG, 8, samples captured after the trigger sample; must be < DEPTH (elaboration error otherwise).
- CNT_W, 32, cycle-counter and timestamp width.
- CAPTURE_IDLE, 1, 1 = capture every cycle; 0 = skip cycles where ch_valid == 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ch_data  in  NUM_CH*CH_W  channel words; channel k occupies bits [k*CH_W +: CH_W].
- ch_valid  in  NUM_CH  per-channel valid bits, stored with each sample.
- arm  in  1  start pre-trigger capture; honoured only in IDLE.
- trig  in  1  trigger; honoured only in ARMED.
- rd_valid  out  1  readout beat available.
- rd_ready  in  1  consumer accepts the beat.
- rd_data  out  CH_W  channel word of the current beat.
- rd_ch  out  $clog2(NUM_CH)  channel index of the current beat.
- rd_chv  out  1  stored ch_valid bit for rd_ch.
- rd_cycle  out  CNT_W  timestamp of the entry being read.
- rd_last  out  1  final beat of the dump.
- state  out  2  0 = IDLE, 1 = ARMED, 2 = POST, 3 = DUMP.
- cycle_count  out  CNT_W  free-running counter.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE, cycle_count = 0.
  - Write pointer, entry count and post counter = 0.
  - rd_valid = 0, rd_last = 0, rd_data = 0, rd_ch = 0, rd_chv = 0, rd_cycle = 0.
  - Reset mid-operation aborts any capture or dump; buffer contents are don't-care.
- cycle_count increments every non-reset cycle and wraps 2^CNT_W-1 -> 0.
- Entry contents: {cycle_count, ch_valid, ch_data}, written at wr_ptr. wr_ptr wraps at DEPTH. count saturates at DEPTH.
- Capture-eligible cycle:
  - CAPTURE_IDLE = 1: every cycle.
  - CAPTURE_IDLE = 0: cycles where |ch_valid, plus the trigger cycle unconditionally.
- IDLE:
  - arm = 1 -> ARMED next cycle; count and wr_ptr are cleared.
  - trig and rd_ready are ignored.
  - Nothing is captured in the cycle arm is sampled.
- ARMED:
  - Capture on eligible cycles. Oldest entries are overwritten once full.
  - trig = 1 -> that cycle's sample is captured, post counter is loaded with POST_TRIG, then -> POST.
  - arm is ignored.
- POST:
  - Each captured eligible sample decrements the post counter.
  - After the POST_TRIG-th sample -> DUMP.
  - trig and arm are ignored.
- DUMP:
  - No capture.
  - Entries are read oldest to newest: start index = (wr_ptr - count) mod DEPTH, count entries in total.
  - Each entry is emitted as NUM_CH beats, rd_ch = 0 .. NUM_CH-1.
  - Beat order is entry-major, channel-minor; rd_cycle is constant across an entry's beats.
- Readout latency: the buffer uses a registered read. The first rd_valid rises on the second cycle in DUMP.
- Handshake:
  - A beat transfers on a cycle with rd_valid & rd_ready.
  - While rd_valid = 1 and rd_ready = 0, all rd_* outputs hold stable.
  - Back-to-back beats give one beat per cycle at full throughput.
- rd_last = 1 only on beat count*NUM_CH.
- On acceptance of the last beat: rd_valid = 0 and state = IDLE on the next cycle. Re-arm is allowed from that cycle.
- Buffer never empty in DUMP, because the trigger sample is always captured.
- arm and trig together in IDLE: only arm acts.

Decomposition:
- Shared package pipeline_trace_pkg holds:
  - state enum TRACE_IDLE / TRACE_ARMED / TRACE_POST / TRACE_DUMP with encodings 0–3.
  - entry-width helper function.
- One sub-module: trace_ram, a simple dual-port DEPTH x (CNT_W+NUM_CH+NUM_CH*CH_W) RAM with a registered read port.
- Control FSM, pointers and beat serializer live in pipeline_trace_buffer.

Test Plan:
1. Reset: hold rst_n = 0 for 2 cycles with arm = trig = 1 -> state = 0, cycle_count = 0, rd_valid = 0; cycle_count reads 1 one cycle after release.
2. Full wrap (defaults, CAPTURE_IDLE = 1, rd_ready = 1):
   - Stimulus: arm at cycle 10, trig at cycle 40.
   - Required: 80 beats; rd_cycle 33..48, each value on 5 consecutive beats.
   - rd_ch cycles 0..4; rd_last on beat 80 only; state = IDLE after it.
3. Partial fill: arm at cycle 10, trig at cycle 13 -> 11 entries with stamps 11..21, 55 beats, rd_last on beat 55.
4. Backpressure: drop rd_ready for 5 cycles after beat 7 -> rd_data, rd_ch, rd_cycle, rd_last stable throughout; beat 8 = entry 1, channel 2; no beat lost or duplicated.
5. CAPTURE_IDLE = 0: ch_valid = 0 on odd cycles, trig on odd cycle 41 -> entries are even stamps plus 41; stored rd_chv = 0 for cycle 41.
6. Reset mid-dump: pulse rst_n low after 7 accepted beats -> next cycle rd_valid = 0, state = 0, cycle_count = 0; a subsequent arm/trig dump is correct. Also run with CNT_W = 4: timestamps wrap 15 -> 0 within one dump.

Source files
------------

// File: rtl/pipeline_trace_pkg.sv
// Shared types and helpers for the pipeline trace buffer.
package pipeline_trace_pkg;

  // Capture controller states; the encoding is visible on the state port.
  typedef enum logic [1:0] {
    TRACE_IDLE  = 2'd0,
    TRACE_ARMED = 2'd1,
    TRACE_POST  = 2'd2,
    TRACE_DUMP  = 2'd3
  } trace_state_e;

  // Width of one stored entry: {timestamp, per-channel valid bits, channel words}.
  function automatic int entry_width(input int cnt_w, input int num_ch, input int ch_w);
    return cnt_w + num_ch + num_ch * ch_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module trace_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // NOTE: the storage array is deliberately not reset; its contents are only
  // read back after being written, so a reset would just cost clear logic.
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; rdata holds its value while re is low.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipeline_trace_buffer.sv
// On-chip trace capture for the pipeline stage channels: circular pre-trigger
// capture, fixed post-trigger window, then an oldest-first beat dump.
module pipeline_trace_buffer
  import pipeline_trace_pkg::*;
#(
  parameter  int NUM_CH       = 5,
  parameter  int CH_W         = 32,
  parameter  int DEPTH        = 16,
  parameter  int POST_TRIG    = 8,
  parameter  int CNT_W        = 32,
  parameter  int CAPTURE_IDLE = 1,
  localparam int CH_IW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CH*CH_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]      ch_valid,
  input  logic                   arm,
  input  logic                   trig,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [CH_W-1:0]        rd_data,
  output logic [CH_IW-1:0]       rd_ch,
  output logic                   rd_chv,
  output logic [CNT_W-1:0]       rd_cycle,
  output logic                   rd_last,
  output logic [1:0]             state,
  output logic [CNT_W-1:0]       cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_width(CNT_W, NUM_CH, CH_W);

  if (POST_TRIG >= DEPTH) begin : g_post_trig_check
    $error("pipeline_trace_buffer: POST_TRIG must be smaller than DEPTH");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("pipeline_trace_buffer: DEPTH must be a power of two and at least 2");
  end

  trace_state_e st;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] post_cnt;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] ent_left;

  logic                   eligible;
  logic                   we;
  logic [EW-1:0]          wdata;
  logic [AW-1:0]          start_idx;
  logic                   accept;
  logic                   last_ch;
  logic                   re;
  logic [AW-1:0]          raddr;
  logic [EW-1:0]          rdata;
  logic [CNT_W-1:0]       ent_stamp;
  logic [NUM_CH-1:0]      ent_chv;
  logic [NUM_CH*CH_W-1:0] ent_data;

  assign state = st;

  // Capture decision, RAM addressing and beat presentation.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    eligible  = 1'b0;
    we        = 1'b0;
    re        = 1'b0;
    raddr     = '0;
    rd_data   = '0;
    rd_chv    = 1'b0;
    rd_cycle  = '0;
    rd_last   = 1'b0;

    // Trigger sample is always eligible so the dump is never empty.
    eligible  = (CAPTURE_IDLE != 0) || (|ch_valid) || (st == TRACE_ARMED && trig);
    we        = eligible && (st == TRACE_ARMED || st == TRACE_POST);
    wdata     = {cycle_count, ch_valid, ch_data};

    // Oldest entry; when the buffer is full count wraps to zero here.
    start_idx = wr_ptr - count[AW-1:0];
    accept    = rd_valid && rd_ready;
    last_ch   = (rd_ch == CH_IW'(NUM_CH - 1));

    // First read is issued on entry to DUMP; later reads are issued as the
    // last channel of an entry is accepted so the next entry lands in time.
    re        = (st == TRACE_DUMP && !rd_valid) ||
                (accept && last_ch && ent_left != CW'(1));
    raddr     = rd_valid ? rd_ptr + AW'(1) : start_idx;

    ent_stamp = rdata[EW-1 -: CNT_W];
    ent_chv   = rdata[NUM_CH*CH_W +: NUM_CH];
    ent_data  = rdata[NUM_CH*CH_W-1:0];

    // Outputs are derived from registered state and the held RAM word, so
    // they stay stable while the consumer stalls.
    if (rd_valid) begin
      rd_data  = ent_data[rd_ch*CH_W +: CH_W];
      rd_chv   = ent_chv[rd_ch];
      rd_cycle = ent_stamp;
      rd_last  = (ent_left == CW'(1)) && last_ch;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Free-running cycle counter used as the sample timestamp.
  always_ff @(posedge clk) begin
    if (!rst_n) cycle_count <= '0;
    else        cycle_count <= cycle_count + CNT_W'(1);
  end

  // Control FSM: write pointer, fill count, post-trigger window, beat serializer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= TRACE_IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
      rd_ptr   <= '0;
      ent_left <= '0;
      rd_valid <= 1'b0;
      rd_ch    <= '0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count != CW'(DEPTH)) count <= count + CW'(1);
      end

      unique case (st)
        TRACE_IDLE: begin
          if (arm) begin
            st     <= TRACE_ARMED;
            wr_ptr <= '0;
            count  <= '0;
          end
        end

        TRACE_ARMED: begin
          if (trig) begin
            post_cnt <= CW'(POST_TRIG);
            st       <= (POST_TRIG == 0) ? TRACE_DUMP : TRACE_POST;
          end
        end

        TRACE_POST: begin
          if (we) begin
            post_cnt <= post_cnt - CW'(1);
            if (post_cnt == CW'(1)) st <= TRACE_DUMP;
          end
        end

        TRACE_DUMP: begin
          if (!rd_valid) begin
            // Read of the oldest entry is in flight this cycle.
            rd_valid <= 1'b1;
            rd_ch    <= '0;
            rd_ptr   <= start_idx;
            ent_left <= count;
          end else if (accept) begin
            if (last_ch) begin
              if (ent_left == CW'(1)) begin
                rd_valid <= 1'b0;
                st       <= TRACE_IDLE;
              end else begin
                rd_ch    <= '0;
                rd_ptr   <= rd_ptr + AW'(1);
                ent_left <= ent_left - CW'(1);
              end
            end else begin
              rd_ch <= rd_ch + CH_IW'(1);
            end
          end
        end

        default: st <= TRACE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Directed, table-driven bench for pipeline_trace_buffer. Three instances:
// defaults, CAPTURE_IDLE = 0, and CNT_W = 4; one is selected per run.
module tb_pipeline_trace_buffer;

  localparam int NUM_CH = 5;
  localparam int CH_W   = 32;
  localparam int NV     = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_CH*CH_W-1:0] ch_data;
  logic [NUM_CH-1:0]      ch_valid;
  logic [2:0]             arm_v;
  logic [2:0]             trig_v;
  logic                   rd_ready;

  logic        v0, v1, v2, chv0, chv1, chv2, l0, l1, l2;
  logic [31:0] d0, d1, d2, cy0, cy1, cc0, cc1;
  logic [3:0]  cy2, cc2;
  logic [2:0]  c0, c1, c2;
  logic [1:0]  s0, s1, s2;

  logic        m_valid, m_chv, m_last;
  logic [31:0] m_data, m_cycle, m_cc;
  logic [2:0]  m_ch;
  logic [1:0]  m_state;

  logic [31:0] cyc;
  int          sel;
  bit          pat;
  logic [31:0] exp_st [16];
  int          n_cmp;
  int          n_bad;

  typedef struct packed {
    logic [1:0]       sel;
    logic [7:0]       arm_at;
    logic [7:0]       trig_at;
    logic             pat;
    logic [7:0]       stall_after;
    logic [4:0]       n;
    logic [15:0][7:0] st;
  } vec_t;

  vec_t vecs [NV];
  int   pat_st [16];

  always #5 clk = ~clk;

  // Reference cycle count: same cycle numbering the DUT stamps with.
  always @(posedge clk) cyc <= rst_n ? cyc + 32'd1 : 32'd0;

  // Channel words encode the cycle and channel; valid pattern optionally
  // drops all channels on odd cycles.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) ch_data[k*CH_W +: CH_W] = (cyc << 4) | 32'(k);
    ch_valid = (pat && cyc[0]) ? '0 : '1;
  end

  pipeline_trace_buffer u_dut0 (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_valid(ch_valid),
    .arm(arm_v[0]), .trig(trig_v[0]), .rd_valid(v0), .rd_ready(rd_ready),
    .rd_data(d0), .rd_ch(c0), .rd_chv(chv0), .rd_cycle(cy0), .rd_last(l0),
    .state(s0), .cycle_count(cc0));

  pipeline_trace_buffer #(.CAPTURE_IDLE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_valid(ch_valid),
    .arm(arm_v[1]), .trig(trig_v[1]), .rd_valid(v1), .rd_ready(rd_ready),
    .rd_data(d1), .rd_ch(c1), .rd_chv(chv1), .rd_cycle(cy1), .rd_last(l1),
    .state(s1), .cycle_count(cc1));

  pipeline_trace_buffer #(.CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_valid(ch_valid),
    .arm(arm_v[2]), .trig(trig_v[2]), .rd_valid(v2), .rd_ready(rd_ready),
    .rd_data(d2), .rd_ch(c2), .rd_chv(chv2), .rd_cycle(cy2), .rd_last(l2),
    .state(s2), .cycle_count(cc2));

  always_comb begin
    m_valid = v0; m_data = d0; m_ch = c0; m_chv = chv0; m_cycle = cy0;
    m_last = l0; m_state = s0; m_cc = cc0;
    if (sel == 1) begin
      m_valid = v1; m_data = d1; m_ch = c1; m_chv = chv1; m_cycle = cy1;
      m_last = l1; m_state = s1; m_cc = cc1;
    end else if (sel == 2) begin
      m_valid = v2; m_data = d2; m_ch = c2; m_chv = chv2; m_cycle = {28'd0, cy2};
      m_last = l2; m_state = s2; m_cc = {28'd0, cc2};
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] act_vec();
    return {40'd0, 5'd0, m_ch, 7'd0, m_last, 7'd0, m_chv, m_cycle, m_data};
  endfunction

  function automatic logic [127:0] exp_vec(input int b, input int total);
    int          e, k;
    logic [31:0] s, cyv, dat;
    logic        chv, last;
    e    = b / NUM_CH;
    k    = b % NUM_CH;
    s    = exp_st[e];
    cyv  = (sel == 2) ? (s & 32'hF) : s;
    dat  = (s << 4) | 32'(k);
    chv  = !(pat && s[0]);
    last = (b == total - 1);
    return {40'd0, 5'd0, 3'(k), 7'd0, last, 7'd0, chv, cyv, dat};
  endfunction

  task automatic wait_cyc(input int n);
    int g;
    g = 0;
    while (cyc != 32'(n) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != 32'(n)) check("reach_cycle_timeout", cyc, n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm_v = '1; trig_v = '1; rd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", m_state, 0);
    check("rst_cycle_count", m_cc, 0);
    check("rst_rd_valid", m_valid, 0);
    check("rst_rd_outputs", {m_last, m_chv, m_ch, m_data, m_cycle}, 0);
    rst_n = 1'b1; arm_v = '0; trig_v = '0;
    @(negedge clk);
    check("cycle_count_after_release", m_cc, 1);
    check("state_after_release", m_state, 0);
  endtask

  task automatic run_capture(input int a, input int t);
    wait_cyc(a);
    arm_v[sel] = 1'b1;
    @(negedge clk);
    arm_v = '0;
    wait_cyc(t);
    trig_v[sel] = 1'b1;
    @(negedge clk);
    trig_v = '0;
  endtask

  // Drains the dump, checking every presented beat (stalled or not) against
  // the expected beat; optional stall window and early stop.
  task automatic collect(input int n_ent, input int stall_after, input int stall_len,
                         input int stop_after, input bit chk_lat);
    int total, b, stall, budget;
    bit seen_dump, lat_done;
    total = n_ent * NUM_CH; b = 0; stall = 0; budget = 0;
    seen_dump = 0; lat_done = 0;
    while (b < total && budget < 600) begin
      @(negedge clk);
      budget++;
      if (stall > 0) begin rd_ready = 1'b0; stall--; end
      else rd_ready = 1'b1;
      if (chk_lat && !lat_done) begin
        if (seen_dump) begin
          check("first_valid_latency", m_valid, 1);
          lat_done = 1;
        end else if (m_state == 2'd3) begin
          check("dump_first_cycle_no_valid", m_valid, 0);
          seen_dump = 1;
        end
      end
      if (m_valid) begin
        check($sformatf("beat%0d", b + 1), act_vec(), exp_vec(b, total));
        if (rd_ready) begin
          b++;
          if (b == stall_after) stall = stall_len;
          if (b == stop_after) return;
        end
      end
    end
    check("beats_accepted", b, total);
    @(negedge clk);
    rd_ready = 1'b1;
    check("valid_low_after_last", m_valid, 0);
    check("idle_after_last", m_state, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    n_cmp = 0; n_bad = 0; sel = 0; pat = 0;
    rst_n = 1'b0; arm_v = '0; trig_v = '0; rd_ready = 1'b1;

    pat_st = '{28, 30, 32, 34, 36, 38, 40, 41, 42, 44, 46, 48, 50, 52, 54, 56};
    vecs[0] = '{sel: 2'd0, arm_at: 8'd10, trig_at: 8'd40, pat: 1'b0, stall_after: 8'd0, n: 5'd16, st: '0};
    vecs[1] = '{sel: 2'd0, arm_at: 8'd10, trig_at: 8'd13, pat: 1'b0, stall_after: 8'd0, n: 5'd11, st: '0};
    vecs[2] = '{sel: 2'd0, arm_at: 8'd10, trig_at: 8'd40, pat: 1'b0, stall_after: 8'd7, n: 5'd16, st: '0};
    vecs[3] = '{sel: 2'd1, arm_at: 8'd10, trig_at: 8'd41, pat: 1'b1, stall_after: 8'd0, n: 5'd16, st: '0};
    vecs[4] = '{sel: 2'd2, arm_at: 8'd10, trig_at: 8'd40, pat: 1'b0, stall_after: 8'd0, n: 5'd16, st: '0};
    for (int i = 0; i < 16; i++) begin
      vecs[0].st[i] = 8'(33 + i);
      vecs[1].st[i] = 8'(11 + i);
      vecs[2].st[i] = 8'(33 + i);
      vecs[3].st[i] = 8'(pat_st[i]);
      vecs[4].st[i] = 8'(33 + i);
    end

    // Table-driven capture/dump runs, each from a fresh reset.
    for (int vi = 0; vi < NV; vi++) begin
      sel = int'(vecs[vi].sel);
      pat = vecs[vi].pat;
      do_reset();
      for (int i = 0; i < 16; i++) exp_st[i] = 32'(vecs[vi].st[i]);
      run_capture(int'(vecs[vi].arm_at), int'(vecs[vi].trig_at));
      collect(int'(vecs[vi].n), (vecs[vi].stall_after == 0) ? -1 : int'(vecs[vi].stall_after),
              5, -1, 1'b1);
    end

    // Re-arm in the first IDLE cycle after a dump, no reset in between.
    sel = 0; pat = 0;
    do_reset();
    for (int i = 0; i < 16; i++) exp_st[i] = 32'(11 + i);
    run_capture(10, 13);
    collect(11, -1, 0, -1, 1'b0);
    a = int'(cyc);
    for (int i = 0; i < 16; i++) exp_st[i] = 32'(a + 1 + i);
    run_capture(a, a + 3);
    collect(11, -1, 0, -1, 1'b1);

    // Reset pulse in the middle of a dump, then a clean capture.
    do_reset();
    for (int i = 0; i < 16; i++) exp_st[i] = 32'(33 + i);
    run_capture(10, 40);
    collect(16, -1, 0, 7, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_dump_rst_valid", m_valid, 0);
    check("mid_dump_rst_state", m_state, 0);
    check("mid_dump_rst_cycle_count", m_cc, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) exp_st[i] = 32'(11 + i);
    run_capture(10, 13);
    collect(11, -1, 0, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
